// File: rtl/mmss_countdown_timer.sv
// Keypad-loaded MM:SS countdown timer producing four registered BCD digits
// for the seven-segment decoder, with run/pause/done control.
module mmss_countdown_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESCALE_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    input  logic       start_pause,
    input  logic       clear,
    output logic [3:0] minute_tens,
    output logic [3:0] minute_unit,
    output logic [3:0] second_tens,
    output logic [3:0] second_unit,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

    state_t                state;
    logic [PRESCALE_W-1:0] prescale;

    logic       digit_ok, time_zero, time_one, can_start;
    logic       borrow_su, borrow_st, borrow_mu;
    logic [3:0] dec_mt, dec_mu, dec_st, dec_su;

    assign digit_ok  = digit_valid && (digit_in <= 4'd9);
    assign time_zero = {minute_tens, minute_unit, second_tens, second_unit} == 16'h0000;
    assign time_one  = {minute_tens, minute_unit, second_tens, second_unit} == 16'h0001;
    assign can_start = !time_zero && (second_tens <= 4'd5);

    // BCD borrow chain; seconds tens wraps to 5, the other digits to 9
    assign borrow_su = (second_unit == 4'd0);
    assign borrow_st = borrow_su && (second_tens == 4'd0);
    assign borrow_mu = borrow_st && (minute_unit == 4'd0);
    assign dec_su = borrow_su ? 4'd9 : second_unit - 4'd1;
    assign dec_st = !borrow_su ? second_tens :
                    (second_tens == 4'd0) ? 4'd5 : second_tens - 4'd1;
    assign dec_mu = !borrow_st ? minute_unit :
                    (minute_unit == 4'd0) ? 4'd9 : minute_unit - 4'd1;
    assign dec_mt = borrow_mu ? minute_tens - 4'd1 : minute_tens;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prescale    <= '0;
            minute_tens <= 4'd0;
            minute_unit <= 4'd0;
            second_tens <= 4'd0;
            second_unit <= 4'd0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            prescale    <= '0;
            minute_tens <= 4'd0;
            minute_unit <= 4'd0;
            second_tens <= 4'd0;
            second_unit <= 4'd0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else if (start_pause) begin
            // A pause on a wrap cycle leaves the prescaler at LAST, so the
            // suppressed decrement fires on the first cycle after resume.
            case (state)
                IDLE: if (can_start) begin
                    state    <= RUNNING;
                    prescale <= '0;
                    running  <= 1'b1;
                end
                RUNNING: begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end
                PAUSED: begin
                    state   <= RUNNING;
                    running <= 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (state)
                IDLE: if (digit_ok) begin
                    minute_tens <= minute_unit;
                    minute_unit <= second_tens;
                    second_tens <= second_unit;
                    second_unit <= digit_in;
                end
                DONE: if (digit_ok) begin
                    minute_tens <= 4'd0;
                    minute_unit <= 4'd0;
                    second_tens <= 4'd0;
                    second_unit <= digit_in;
                    state       <= IDLE;
                    done        <= 1'b0;
                end
                RUNNING: begin
                    if (prescale == LAST) begin
                        prescale    <= '0;
                        minute_tens <= dec_mt;
                        minute_unit <= dec_mu;
                        second_tens <= dec_st;
                        second_unit <= dec_su;
                        if (time_one) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        prescale <= prescale + PRESCALE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Bench for mmss_countdown_timer: vector table, directed corner sequences and
// random stimulus against a seconds-based reference model.
module tb_mmss_countdown_timer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       start_pause = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] minute_tens, minute_unit, second_tens, second_unit;
    logic       running, done;

    mmss_countdown_timer #(.TICKS_PER_SEC(T), .PRESCALE_W(3)) dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit_in(digit_in),
        .start_pause(start_pause), .clear(clear),
        .minute_tens(minute_tens), .minute_unit(minute_unit),
        .second_tens(second_tens), .second_unit(second_unit),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: 0 idle, 1 running, 2 paused, 3 done; m_dig[0] is minute tens
    int m_state, m_presc;
    int m_dig[4];

    typedef struct {
        logic        dv;
        logic [3:0]  din;
        logic        sp;
        logic        clr;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [23:0] pk(int mt, int mu, int st, int su, int r, int d);
        return {4'(mt), 4'(mu), 4'(st), 4'(su), 4'(r), 4'(d)};
    endfunction

    function automatic vec_t mkv(logic dv, int din, logic sp, logic clr,
                                 int mt, int mu, int st, int su, int r, int d);
        vec_t v;
        v.dv = dv; v.din = 4'(din); v.sp = sp; v.clr = clr;
        v.exp = pk(mt, mu, st, su, r, d);
        return v;
    endfunction

    function automatic logic [23:0] dut_out();
        return {minute_tens, minute_unit, second_tens, second_unit,
                3'b0, running, 3'b0, done};
    endfunction

    function automatic logic [23:0] model_out();
        return pk(m_dig[0], m_dig[1], m_dig[2], m_dig[3],
                  int'(m_state == 1), int'(m_state == 3));
    endfunction

    function automatic int secs();
        return (m_dig[0] * 10 + m_dig[1]) * 60 + m_dig[2] * 10 + m_dig[3];
    endfunction

    task automatic model_reset();
        m_state = 0; m_presc = 0;
        for (int k = 0; k < 4; k++) m_dig[k] = 0;
    endtask

    task automatic model_step(input logic dv, input logic [3:0] din,
                              input logic sp, input logic clr);
        int t;
        if (clr) begin
            model_reset();
        end else if (sp) begin
            if (m_state == 0 && secs() != 0 && m_dig[2] <= 5) begin
                m_state = 1; m_presc = 0;
            end else if (m_state == 1) m_state = 2;
            else if (m_state == 2) m_state = 1;
        end else if (m_state == 0) begin
            if (dv && din <= 9) begin
                m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2];
                m_dig[2] = m_dig[3]; m_dig[3] = int'(din);
            end
        end else if (m_state == 3) begin
            if (dv && din <= 9) begin
                m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0; m_dig[3] = int'(din);
                m_state = 0;
            end
        end else if (m_state == 1) begin
            if (m_presc == T - 1) begin
                m_presc = 0;
                t = secs() - 1;
                m_dig[0] = (t / 60) / 10; m_dig[1] = (t / 60) % 10;
                m_dig[2] = (t % 60) / 10; m_dig[3] = (t % 60) % 10;
                if (t == 0) m_state = 3;
            end else m_presc++;
        end
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h (MMSS,run,done) expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic dv, input logic [3:0] din, input logic sp, input logic clr);
        digit_valid = dv; digit_in = din; start_pause = sp; clear = clr;
        @(posedge clk); #1;
        model_step(dv, din, sp, clr);
        digit_valid = 1'b0; start_pause = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'(a), 1'b0, 1'b0);
        step(1'b1, 4'(b), 1'b0, 1'b0);
        step(1'b1, 4'(c), 1'b0, 1'b0);
        step(1'b1, 4'(d), 1'b0, 1'b0);
    endtask

    // Reset asserted between edges must clear outputs before any clock edge
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 chk("async reset", dut_out(), pk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic dv, sp, clr;
        logic [3:0] din;
        int r;

        tbl[0]  = mkv(1, 1, 0, 0,  0, 0, 0, 1, 0, 0);
        tbl[1]  = mkv(1, 2, 0, 0,  0, 0, 1, 2, 0, 0);
        tbl[2]  = mkv(1, 3, 0, 0,  0, 1, 2, 3, 0, 0);
        tbl[3]  = mkv(1, 4, 0, 0,  1, 2, 3, 4, 0, 0);
        tbl[4]  = mkv(1, 5, 0, 0,  2, 3, 4, 5, 0, 0);
        tbl[5]  = mkv(1, 12, 0, 0, 2, 3, 4, 5, 0, 0);
        tbl[6]  = mkv(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[7]  = mkv(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[8]  = mkv(1, 2, 0, 0,  0, 0, 0, 2, 0, 0);
        tbl[9]  = mkv(0, 0, 1, 0,  0, 0, 0, 2, 1, 0);
        tbl[10] = mkv(0, 0, 0, 0,  0, 0, 0, 2, 1, 0);
        tbl[11] = mkv(0, 0, 0, 0,  0, 0, 0, 2, 1, 0);
        tbl[12] = mkv(0, 0, 0, 0,  0, 0, 0, 2, 1, 0);
        tbl[13] = mkv(0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
        tbl[14] = mkv(0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
        tbl[15] = mkv(0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
        tbl[16] = mkv(0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
        tbl[17] = mkv(0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[18] = mkv(0, 0, 1, 0,  0, 0, 0, 0, 0, 1);
        tbl[19] = mkv(1, 11, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[20] = mkv(1, 7, 0, 0,  0, 0, 0, 7, 0, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset state", dut_out(), pk(0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].dv, tbl[i].din, tbl[i].sp, tbl[i].clr);
            chk($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        load(0, 1, 2, 3); step(0, 0, 1, 0); idle(2);
        chk("running 01:23", dut_out(), pk(0, 1, 2, 3, 1, 0));
        do_reset();

        load(0, 1, 0, 0); step(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("01:00 holds", dut_out(), pk(0, 1, 0, 0, 1, 0));
        end
        idle(1); chk("first tick 00:59", dut_out(), pk(0, 0, 5, 9, 1, 0));
        idle(3); chk("hold 00:59", dut_out(), pk(0, 0, 5, 9, 1, 0));
        idle(1); chk("second tick 00:58", dut_out(), pk(0, 0, 5, 8, 1, 0));

        load(1, 0, 0, 0); step(0, 0, 1, 0); idle(3);
        step(0, 0, 1, 0); chk("pause on wrap", dut_out(), pk(1, 0, 0, 0, 0, 0));
        idle(5); chk("paused hold", dut_out(), pk(1, 0, 0, 0, 0, 0));
        step(0, 0, 1, 0); chk("resume", dut_out(), pk(1, 0, 0, 0, 1, 0));
        idle(1); chk("deferred tick", dut_out(), pk(0, 9, 5, 9, 1, 0));

        load(9, 9, 5, 9); step(0, 0, 1, 0); idle(4);
        chk("99:59 tick", dut_out(), pk(9, 9, 5, 8, 1, 0));
        load(9, 0, 0, 0); step(0, 0, 1, 0); idle(4);
        chk("90:00 tick", dut_out(), pk(8, 9, 5, 9, 1, 0));

        load(0, 0, 9, 9); step(0, 0, 1, 0);
        chk("start 00:99", dut_out(), pk(0, 0, 9, 9, 0, 0));
        step(0, 0, 0, 1); step(0, 0, 1, 0);
        chk("start 00:00", dut_out(), pk(0, 0, 0, 0, 0, 0));

        load(0, 5, 1, 7); step(0, 0, 1, 0); idle(2); step(0, 0, 1, 0);
        chk("paused 05:17", dut_out(), pk(0, 5, 1, 7, 0, 0));
        step(0, 0, 0, 1); chk("clear paused", dut_out(), pk(0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 99);
                dv = 1'b0; sp = 1'b0; clr = 1'b0;
                din = 4'($urandom_range(0, 15));
                if (r < 30) dv = 1'b1;
                else if (r < 40) sp = 1'b1;
                else if (r < 43) clr = 1'b1;
                else if (r < 45) begin clr = 1'b1; dv = 1'b1; end
                else if (r < 46) begin clr = 1'b1; sp = 1'b1; end
                step(dv, din, sp, clr);
                chk("random", dut_out(), model_out());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmss_countdown_timer.md
Name: mmss_countdown_timer

Overview:
- Keypad-loaded MM:SS countdown timer that produces the four BCD digits (minute tens, minute units, second tens, second units) consumed by the 4-digit seven-segment decoder stage directly downstream.
- Contains a digit-entry shift register, a one-second prescaler, a BCD borrow-chain decrementer and a run/pause/done state machine.
- All outputs are registered, so the downstream decoder sees glitch-free digits.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second tick; must be >= 2; benches use 4.
- PRESCALE_W, 26, prescaler counter width; must satisfy 2^PRESCALE_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- digit_valid  input  1  single-cycle strobe; digit_in is valid.
- digit_in  input  4  keypad BCD digit; values 10..15 are ignored.
- start_pause  input  1  single-cycle strobe; starts, pauses or resumes the countdown.
- clear  input  1  single-cycle strobe; aborts and zeroes the time.
- minute_tens  output  4  BCD minute tens (0..9).
- minute_unit  output  4  BCD minute units (0..9).
- second_tens  output  4  BCD second tens (0..9 while entering, 0..5 while counting).
- second_unit  output  4  BCD second units (0..9).
- running  output  1  high while in the RUNNING state.
- done  output  1  high while in the DONE state.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately):
  - state = IDLE; all four digits = 0; prescaler = 0; running = 0; done = 0.
  - Normal operation resumes on the first clk edge after reset deasserts.
- Input priority within a cycle: reset > clear > start_pause > digit_valid > tick.
- States: IDLE, RUNNING, PAUSED, DONE. running = (state==RUNNING); done = (state==DONE); both are registered with the state.
- clear (any state): next state IDLE, all digits 0, prescaler 0.
- Digit entry (IDLE only; digit_in <= 9):
  - Shift left one position: minute_tens<=minute_unit, minute_unit<=second_tens, second_tens<=second_unit, second_unit<=digit_in.
  - The old minute_tens value is discarded.
  - digit_in > 9 is ignored; no change.
  - digit_valid in RUNNING or PAUSED is ignored.
- Digit entry in DONE: all digits cleared, then digit_in loaded into second_unit; next state IDLE. An invalid digit (>9) is ignored and the state stays DONE.
- start_pause transitions:
  - IDLE -> RUNNING only if time != 00:00 and second_tens <= 5. Otherwise ignored and the state stays IDLE. Prescaler is zeroed on this transition.
  - RUNNING -> PAUSED; the prescaler holds its value.
  - PAUSED -> RUNNING; the prescaler resumes from its held value.
  - DONE: ignored.
- Prescaler (RUNNING only):
  - Increments every cycle.
  - When it equals TICKS_PER_SEC-1, it wraps to 0 and a tick occurs in that same cycle.
  - First decrement therefore lands TICKS_PER_SEC cycles after the start strobe edge.
- Tick decrement (BCD borrow chain, same edge):
  - second_unit: 0 -> 9 with borrow, else -1.
  - second_tens: on borrow, 0 -> 5 with borrow, else -1.
  - minute_unit: on borrow, 0 -> 9 with borrow, else -1.
  - minute_tens: on borrow, -1. Never underflows, because 00:00 is never decremented.
- Completion: a tick while time == 00:01 sets the digits to 00:00 and the next state to DONE on the same edge. done stays high until clear or a digit entry.
- start_pause in the same cycle as a tick while RUNNING: pause wins and the decrement is suppressed. The prescaler holds at TICKS_PER_SEC-1, so the suppressed decrement occurs on the first RUNNING cycle after resume.
- clear in the same cycle as a tick: clear wins; no decrement.
- Maximum time 99:59 counts down normally. After 99:59, the next tick gives 99:58; after 90:00, the next tick gives 89:59.

Test Plan:
- reset pulse mid-RUNNING at 01:23 -> outputs immediately 00:00, running=0, done=0, before the next clk edge.
- digits 1,2,3,4 strobed in IDLE -> 12:34; a further digit 5 -> 23:45; digit_in=12 -> unchanged.
- TICKS_PER_SEC=4, load 01:00, start -> 00:59 exactly 4 cycles after the start edge; then 00:58 4 cycles later; running=1 throughout.
- load 00:02, start -> 00:01 after 4 cycles, 00:00 after 8 with done=1, running=0 on the same edge. A following start_pause is ignored; digit 7 -> 00:07 and the state returns to IDLE.
- load 10:00, start, pause on the cycle the prescaler hits 3 -> digits stay 10:00, state PAUSED; resume -> 09:59 one cycle later.
- load 00:99 (invalid, second_tens=9) or 00:00, start -> stays IDLE, running=0. clear during PAUSED at 05:17 -> 00:00, IDLE.
